service_arbiter: RTL and testbench
==================================

# service_arbiter

Central sequencer between the SPDT service-select switches, the shared push buttons and the shared 16-bit seven-segment display. It grants exactly one watch service (clock, alarm, stopwatch, …) ownership at a time and enables only that service. It routes button presses and display data to and from the owner, and runs each session's finish handshake. Round-robin arbitration applies when several switches are up.

## Interface
- N_SVC, 4, number of services
- SEG_W, 16, display bus width
- FINISH_TIMEOUT, 1000, cycles to wait for svc_finish after enable drop
- BLANK_SEG, 16'h0000, display pattern when no owner

- clk  in  1  system clock, rising-edge
- reset  in  1  synchronous, active-high
- spdt  in  N_SVC  switch levels, already synchronized
- push_m  in  1  mode button level, debounced
- push_u  in  1  up button level, debounced
- svc_seg  in  N_SVC*SEG_W  service i display at [i*SEG_W +: SEG_W]
- svc_finish  in  N_SVC  one-cycle finish pulse per service
- svc_en  out  N_SVC  one-hot enable to owner (drives its SPDT input)
- svc_push_m  out  N_SVC  one-cycle mode pulse to owner only
- svc_push_u  out  N_SVC  one-cycle up pulse to owner only
- segments  out  SEG_W  display bus
- owner  out  clog2(N_SVC)  current or last owner index
- busy  out  1  high in ACTIVE or DRAIN
- err_timeout  out  1  one-cycle pulse on finish timeout

## Operation
- States: IDLE, ACTIVE, DRAIN.
- Per-service lock bit, set when a session ends while that switch is still high, cleared on any cycle that switch is low.
- IDLE: cand = spdt & ~lock.
  - If cand ≠ 0, pick the first set index strictly after last_owner, cyclic.
  - Load owner and last_owner with it, then go to ACTIVE.
  - Otherwise stay in IDLE.
- ACTIVE: svc_en = onehot(owner).
  - spdt[owner] low → DRAIN.
  - svc_finish[owner] high (service-initiated exit) → set lock[owner], then IDLE.
  - If both occur in the same cycle, finish wins → IDLE, and lock is not set.
- DRAIN: svc_en = 0, timer counts.
  - svc_finish[owner] → IDLE.
  - Timer reaches FINISH_TIMEOUT-1 without finish → err_timeout pulse, then IDLE.
  - Timer clears on DRAIN entry.
- svc_finish from any non-owner, or in IDLE, is ignored.
- Buttons are rising-edge detected against a registered previous level.
  - An edge detected in ACTIVE produces a pulse on bit [owner] only.
  - Edges in IDLE or DRAIN are dropped.
  - push_m and push_u edges in the same cycle both forward.
- segments shows svc_seg[owner] in ACTIVE and DRAIN, and BLANK_SEG in IDLE.
- Reset values:
  - State IDLE, lock = 0, last_owner = N_SVC-1 (so index 0 has first priority).
  - owner = 0, svc_en = 0, all pulses 0, segments = BLANK_SEG, busy = 0, err_timeout = 0, timer = 0, edge registers = 0.

## Timing
- All outputs are registered.
- Grant: cand nonzero at edge t → svc_en, owner and busy valid after edge t+1.
- Release: spdt[owner] falls at t → svc_en = 0 after t+1.
- Finish: finish sampled at t → busy = 0 after t+1. A new grant is possible at the earliest by t+2.
- Button: level rises between edges t-1 and t → svc_push_m[owner] high for exactly cycle t+1.
- Display: svc_seg change at t → segments updated after t+1.
- Timeout: err_timeout asserts FINISH_TIMEOUT cycles after DRAIN entry, with state returning to IDLE on the same edge.
- Reset mid-session: svc_en drops on the next edge. No finish is awaited and no lock is kept.

## Structure
- service_pkg holds:
  - state enum {IDLE, ACTIVE, DRAIN}
  - N_SVC and SEG_W defaults
  - BLANK_SEG
  - the service index constants (SVC_CLOCK, SVC_ALARM, SVC_STOPWATCH, …)
- One combinational sub-module, rr_pick (req, last → grant index, valid), keeps the rotation logic testable on its own.
- Edge detect, timer, lock bits and output registers stay in the top module.

## Test plan
- Reset held 3 cycles, then spdt = 0 → segments = 16'h0000, svc_en = 0, busy = 0, owner = 0.
- spdt = 4'b0100 → after 1 cycle svc_en = 4'b0100, owner = 2; segments track svc_seg[2]; a push_m press gives exactly one 1-cycle svc_push_m = 4'b0100 and zero pulses to other services.
- spdt = 4'b1010 from reset:
  - owner 1 is granted first.
  - Drop spdt[1], pulse svc_finish[1] → owner 3 is granted 2 cycles later.
  - Repeat with spdt = 4'b1010 → owner 1 (rotation wraps).
- Owner 2 in ACTIVE with spdt[2] low and no finish → err_timeout pulses once, FINISH_TIMEOUT cycles after DRAIN entry; state returns to IDLE.
- Owner 0 pulses svc_finish while spdt[0] stays high → IDLE; no re-grant of service 0 until spdt[0] toggles low then high; other raised switches are granted meanwhile.
- Reset asserted mid-ACTIVE with a push_m edge in the same cycle → no svc_push_m pulse, all outputs at reset values one edge later.

Source files
------------

// File: rtl/service_pkg.sv
// rtl/service_pkg.sv - shared types and constants for the watch service arbiter
//
// Contents:
//   state_t       arbiter state encoding (IDLE, ACTIVE, DRAIN)
//   N_SVC_DEF     default number of services
//   SEG_W_DEF     default display bus width
//   BLANK_SEG     display pattern shown while no service owns the display
//   SVC_*         service index constants
//   idx_w()       width of an index into n services (at least 1 bit)
package service_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam int N_SVC_DEF = 4;
  localparam int SEG_W_DEF = 16;

  localparam logic [SEG_W_DEF-1:0] BLANK_SEG = 16'h0000;

  localparam int SVC_CLOCK     = 0;
  localparam int SVC_ALARM     = 1;
  localparam int SVC_STOPWATCH = 2;
  localparam int SVC_TIMER     = 3;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/service_arbiter_rr_pick.sv
// rtl/service_arbiter_rr_pick.sv - combinational round-robin pick after a given index
//
// Ports:
//   req    in   N    request vector
//   last   in   IW   index granted most recently
//   grant  out  IW   first set request index strictly after last, cyclic
//   valid  out  1    at least one request is set
module rr_pick
  import service_pkg::*;
#(
  parameter int N  = N_SVC_DEF,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] grant,
  output logic          valid
);

  // Offsets 1..N walk every index once, starting just after last;
  // offset N lands on last itself so it is picked only when it is alone.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!valid && req[(int'(last) + k) % N]) begin
        valid = 1'b1;
        grant = IW'((int'(last) + k) % N);
      end
    end
  end

endmodule

// File: rtl/service_arbiter.sv
// rtl/service_arbiter.sv - grants one watch service at a time the buttons and display
//
// Ports:
//   clk          in   1            system clock, rising edge
//   reset        in   1            synchronous, active-high
//   spdt         in   N_SVC        synchronized switch levels
//   push_m       in   1            debounced mode button level
//   push_u       in   1            debounced up button level
//   svc_seg      in   N_SVC*SEG_W  per-service display data, service i at [i*SEG_W +: SEG_W]
//   svc_finish   in   N_SVC        per-service one-cycle finish pulse
//   svc_en       out  N_SVC        one-hot enable to the owner
//   svc_push_m   out  N_SVC        one-cycle mode pulse to the owner
//   svc_push_u   out  N_SVC        one-cycle up pulse to the owner
//   segments     out  SEG_W        display bus
//   owner        out  OW           current or last owner index
//   busy         out  1            session in progress (ACTIVE or DRAIN)
//   err_timeout  out  1            one-cycle pulse when a drained service never finished
module service_arbiter
  import service_pkg::*;
#(
  parameter int                N_SVC          = N_SVC_DEF,
  parameter int                SEG_W          = SEG_W_DEF,
  parameter int                FINISH_TIMEOUT = 1000,
  parameter logic [SEG_W-1:0]  BLANK_SEG      = service_pkg::BLANK_SEG,
  parameter int                OW             = idx_w(N_SVC)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_SVC-1:0]         spdt,
  input  logic                     push_m,
  input  logic                     push_u,
  input  logic [N_SVC*SEG_W-1:0]   svc_seg,
  input  logic [N_SVC-1:0]         svc_finish,
  output logic [N_SVC-1:0]         svc_en,
  output logic [N_SVC-1:0]         svc_push_m,
  output logic [N_SVC-1:0]         svc_push_u,
  output logic [SEG_W-1:0]         segments,
  output logic [OW-1:0]            owner,
  output logic                     busy,
  output logic                     err_timeout
);

  localparam int TW = (FINISH_TIMEOUT > 1) ? $clog2(FINISH_TIMEOUT) : 1;

  state_t             state_q, state_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [OW-1:0]      last_q, last_d;
  logic [N_SVC-1:0]   lock_q, lock_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               pm_prev_q, pm_prev_d;
  logic               pu_prev_q, pu_prev_d;
  logic [N_SVC-1:0]   en_q, en_d;
  logic [N_SVC-1:0]   pm_q, pm_d;
  logic [N_SVC-1:0]   pu_q, pu_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic [OW-1:0]      pick;
  logic               pick_valid;
  logic               fin_own;
  logic               sw_own;
  logic               timeout_hit;
  logic [N_SVC-1:0]   owner_onehot;

  // Locked switches must be lowered before they can win again.
  rr_pick #(
    .N  (N_SVC),
    .IW (OW)
  ) u_rr_pick (
    .req   (spdt & ~lock_q),
    .last  (last_q),
    .grant (pick),
    .valid (pick_valid)
  );

  assign fin_own      = svc_finish[owner_q];
  assign sw_own       = spdt[owner_q];
  assign owner_onehot = N_SVC'(1) << owner_q;
  assign timeout_hit  = (state_q == DRAIN) && !fin_own &&
                        (timer_q == TW'(FINISH_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      last_q    <= OW'(N_SVC - 1);
      lock_q    <= '0;
      timer_q   <= '0;
      pm_prev_q <= 1'b0;
      pu_prev_q <= 1'b0;
      en_q      <= '0;
      pm_q      <= '0;
      pu_q      <= '0;
      seg_q     <= BLANK_SEG;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      lock_q    <= lock_d;
      timer_q   <= timer_d;
      pm_prev_q <= pm_prev_d;
      pu_prev_q <= pu_prev_d;
      en_q      <= en_d;
      pm_q      <= pm_d;
      pu_q      <= pu_d;
      seg_q     <= seg_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  // Next-state: grant, session end, drain timer and lock bookkeeping.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    timer_d = '0;
    lock_d  = lock_q & spdt;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = ACTIVE;
          owner_d = pick;
          last_d  = pick;
        end
      end
      ACTIVE: begin
        // A finish beats a simultaneous switch drop; the lock only sticks
        // if the switch is still up.
        if (fin_own) begin
          state_d = IDLE;
          if (sw_own) lock_d[owner_q] = 1'b1;
        end else if (!sw_own) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fin_own || timeout_hit) begin
          state_d = IDLE;
          if (sw_own) lock_d[owner_q] = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register inputs: everything follows the current state, so
  // outputs settle one edge after the state changes.
  always_comb begin
    pm_prev_d = push_m;
    pu_prev_d = push_u;
    en_d      = (state_q == ACTIVE) ? owner_onehot : '0;
    pm_d      = (state_q == ACTIVE && push_m && !pm_prev_q) ? owner_onehot : '0;
    pu_d      = (state_q == ACTIVE && push_u && !pu_prev_q) ? owner_onehot : '0;
    seg_d     = (state_q == IDLE) ? BLANK_SEG : svc_seg[owner_q*SEG_W +: SEG_W];
    busy_d    = (state_q != IDLE);
    err_d     = timeout_hit;
  end

  assign svc_en      = en_q;
  assign svc_push_m  = pm_q;
  assign svc_push_u  = pu_q;
  assign segments    = seg_q;
  assign owner       = owner_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_service_arbiter.sv
// tb/tb_service_arbiter.sv - directed self-checking bench for service_arbiter
module tb_service_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int FT = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   spdt;
  logic           push_m;
  logic           push_u;
  logic [N*W-1:0] svc_seg;
  logic [N-1:0]   svc_finish;
  logic [N-1:0]   svc_en;
  logic [N-1:0]   svc_push_m;
  logic [N-1:0]   svc_push_u;
  logic [W-1:0]   segments;
  logic [1:0]     owner;
  logic           busy;
  logic           err_timeout;

  int errors = 0;
  int checks = 0;

  service_arbiter #(
    .N_SVC          (N),
    .SEG_W          (W),
    .FINISH_TIMEOUT (FT),
    .BLANK_SEG      (16'h0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .spdt        (spdt),
    .push_m      (push_m),
    .push_u      (push_u),
    .svc_seg     (svc_seg),
    .svc_finish  (svc_finish),
    .svc_en      (svc_en),
    .svc_push_m  (svc_push_m),
    .svc_push_u  (svc_push_u),
    .segments    (segments),
    .owner       (owner),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset      = 1'b1;
    spdt       = '0;
    push_m     = 1'b0;
    push_u     = 1'b0;
    svc_finish = '0;
    step(); step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    step();
    checks++; if (segments !== 16'h0000) begin errors++; $display("FAIL reset_seg: got %h want 0000", segments); end
    checks++; if (svc_en !== 4'b0000) begin errors++; $display("FAIL reset_en: got %b want 0000", svc_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d want 0", owner); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_timeout); end
  endtask

  task automatic test_grant_and_buttons();
    svc_seg[2*W +: W] = 16'hA5C3;
    spdt = 4'b0100;
    step(); step();
    checks++; if (owner !== 2'd2) begin errors++; $display("FAIL grant_owner: got %0d want 2", owner); end
    checks++; if (svc_en !== 4'b0100) begin errors++; $display("FAIL grant_en: got %b want 0100", svc_en); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL grant_busy: got %b want 1", busy); end
    checks++; if (segments !== 16'hA5C3) begin errors++; $display("FAIL grant_seg: got %h want a5c3", segments); end
    svc_seg[2*W +: W] = 16'h1234;
    step();
    checks++; if (segments !== 16'h1234) begin errors++; $display("FAIL seg_track: got %h want 1234", segments); end
    svc_finish = 4'b0001;
    step();
    svc_finish = 4'b0000;
    step();
    checks++; if (svc_en !== 4'b0100 || busy !== 1'b1) begin errors++; $display("FAIL foreign_finish: got en=%b busy=%b want en=0100 busy=1", svc_en, busy); end
    push_m = 1'b1;
    step();
    checks++; if (svc_push_m !== 4'b0100) begin errors++; $display("FAIL push_m_pulse: got %b want 0100", svc_push_m); end
    checks++; if (svc_push_u !== 4'b0000) begin errors++; $display("FAIL push_u_quiet: got %b want 0000", svc_push_u); end
    step();
    checks++; if (svc_push_m !== 4'b0000) begin errors++; $display("FAIL push_m_one_cycle: got %b want 0000", svc_push_m); end
    push_m = 1'b0;
    step();
    push_m = 1'b1;
    push_u = 1'b1;
    step();
    checks++; if (svc_push_m !== 4'b0100 || svc_push_u !== 4'b0100) begin errors++; $display("FAIL push_both: got m=%b u=%b want 0100 0100", svc_push_m, svc_push_u); end
    push_m = 1'b0;
    push_u = 1'b0;
    step();
    spdt = 4'b0000;
    step();
    svc_finish = 4'b0100;
    step();
    svc_finish = 4'b0000;
    checks++; if (svc_en !== 4'b0000) begin errors++; $display("FAIL drain_en: got %b want 0000", svc_en); end
    step();
    checks++; if (busy !== 1'b0 || segments !== 16'h0000) begin errors++; $display("FAIL finish_idle: got busy=%b seg=%h want 0 0000", busy, segments); end
  endtask

  task automatic test_rotation();
    apply_reset();
    spdt = 4'b1010;
    step(); step();
    checks++; if (owner !== 2'd1 || svc_en !== 4'b0010) begin errors++; $display("FAIL rot_first: got owner=%0d en=%b want 1 0010", owner, svc_en); end
    spdt       = 4'b1000;
    svc_finish = 4'b0010;
    step();
    svc_finish = 4'b0000;
    step();
    checks++; if (svc_en !== 4'b0000) begin errors++; $display("FAIL rot_gap: got %b want 0000", svc_en); end
    step();
    checks++; if (owner !== 2'd3 || svc_en !== 4'b1000) begin errors++; $display("FAIL rot_second: got owner=%0d en=%b want 3 1000", owner, svc_en); end
    checks++; if (segments !== svc_seg[3*W +: W]) begin errors++; $display("FAIL rot_seg: got %h want %h", segments, svc_seg[3*W +: W]); end
    spdt       = 4'b1010;
    svc_finish = 4'b1000;
    step();
    svc_finish = 4'b0000;
    step(); step();
    checks++; if (owner !== 2'd1 || svc_en !== 4'b0010) begin errors++; $display("FAIL rot_wrap: got owner=%0d en=%b want 1 0010", owner, svc_en); end
  endtask

  task automatic test_timeout();
    int first;
    int pulses;
    first  = -1;
    pulses = 0;
    apply_reset();
    spdt = 4'b0100;
    step(); step();
    checks++; if (owner !== 2'd2) begin errors++; $display("FAIL to_owner: got %0d want 2", owner); end
    spdt = 4'b0000;
    step();
    for (int k = 1; k <= FT + 4; k++) begin
      step();
      if (k == 1) begin
        checks++; if (svc_en !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL to_drain: got en=%b busy=%b want 0000 1", svc_en, busy); end
        push_m = 1'b1;
      end
      if (k == 2) begin
        checks++; if (svc_push_m !== 4'b0000) begin errors++; $display("FAIL to_push_dropped: got %b want 0000", svc_push_m); end
        push_m = 1'b0;
      end
      if (k == FT + 1) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle: got busy=%b want 0", busy); end
      end
      if (err_timeout === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    checks++; if (first != FT) begin errors++; $display("FAIL to_latency: got %0d want %0d", first, FT); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL to_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_lock();
    apply_reset();
    spdt = 4'b0101;
    step(); step();
    checks++; if (owner !== 2'd0 || svc_en !== 4'b0001) begin errors++; $display("FAIL lock_first: got owner=%0d en=%b want 0 0001", owner, svc_en); end
    svc_finish = 4'b0001;
    step();
    svc_finish = 4'b0000;
    step(); step();
    checks++; if (owner !== 2'd2 || svc_en !== 4'b0100) begin errors++; $display("FAIL lock_other: got owner=%0d en=%b want 2 0100", owner, svc_en); end
    svc_finish = 4'b0100;
    step();
    svc_finish = 4'b0000;
    step(); step(); step();
    checks++; if (busy !== 1'b0 || svc_en !== 4'b0000) begin errors++; $display("FAIL lock_hold: got busy=%b en=%b want 0 0000", busy, svc_en); end
    spdt = 4'b0100;
    step();
    spdt = 4'b0101;
    step(); step();
    checks++; if (owner !== 2'd0 || svc_en !== 4'b0001) begin errors++; $display("FAIL lock_release: got owner=%0d en=%b want 0 0001", owner, svc_en); end
  endtask

  task automatic test_reset_mid_active();
    reset  = 1'b1;
    push_m = 1'b1;
    step();
    checks++; if (svc_push_m !== 4'b0000) begin errors++; $display("FAIL rst_push: got %b want 0000", svc_push_m); end
    checks++; if (svc_en !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL rst_en_busy: got en=%b busy=%b want 0000 0", svc_en, busy); end
    checks++; if (owner !== 2'd0 || segments !== 16'h0000) begin errors++; $display("FAIL rst_owner_seg: got owner=%0d seg=%h want 0 0000", owner, segments); end
    reset  = 1'b0;
    push_m = 1'b0;
    step(); step();
    checks++; if (owner !== 2'd0 || svc_en !== 4'b0001) begin errors++; $display("FAIL rst_no_lock: got owner=%0d en=%b want 0 0001", owner, svc_en); end
  endtask

  initial begin
    reset      = 1'b1;
    spdt       = '0;
    push_m     = 1'b0;
    push_u     = 1'b0;
    svc_finish = '0;
    svc_seg    = 64'h4444_3333_2222_1111;
    test_reset();
    test_grant_and_buttons();
    test_rotation();
    test_timeout();
    test_lock();
    test_reset_mid_active();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
